f1_start_lights: RTL and testbench

//   Start-light sequencer that consumes the one-cycle tick from the clock

---
 rtl/f1_start_lights_if.sv | 24 ++
 rtl/f1_start_lights.sv | 103 ++++++++++
 tb/tb_f1_start_lights.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/f1_start_lights_if.sv
// Bus between the start-light sequencer and its divider/lamp-bar neighbours.
// The master drives enable/tick/trigger; the slave (the sequencer) drives lamps and status.
interface f1_start_lights_if #(
   parameter int N_LIGHTS = 8
);
   logic                en;
   logic                tick;
   logic                trigger;
   logic [N_LIGHTS-1:0] lights;
   logic                cmd_seq;
   logic                cmd_delay;
   logic                busy;
   logic                done;

   modport master (
      output en, tick, trigger,
      input  lights, cmd_seq, cmd_delay, busy, done
   );

   modport slave (
      input  en, tick, trigger,
      output lights, cmd_seq, cmd_delay, busy, done
   );
endinterface

// File: rtl/f1_start_lights.sv
// F1 start-light sequencer: fills the lamps one per divider tick, holds them
// for a pseudo-random number of ticks taken from a free-running LFSR, then blanks them.
//
// state | meaning
// IDLE  | lamps off, waiting for a trigger rising edge
// FILL  | one more lamp lit per tick until all are on
// HOLD  | all lamps on, delay_cnt_q counts the random hold down in ticks
module f1_start_lights #(
   parameter int N_LIGHTS = 8,
   parameter int LFSR_W   = 7
) (
   input logic              clk,
   input logic              rst,
   f1_start_lights_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [N_LIGHTS-1:0] lights_q;
   logic [LFSR_W-1:0]   lfsr_q;
   logic [LFSR_W-1:0]   delay_cnt_q;
   logic                trig_q;
   logic                done_q;
   logic                start;
   logic                fill_last;
   logic                hold_last;

   assign start     = bus.trigger & ~trig_q;
   // The lamp bar is a thermometer code, so the next tick fills it once all but the top lamp are lit.
   assign fill_last = bus.tick & (&lights_q[N_LIGHTS-2:0]);
   assign hold_last = bus.tick & (delay_cnt_q == LFSR_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else if (bus.en) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)     state_d = FILL;
         FILL:    if (fill_last) state_d = HOLD;
         HOLD:    if (hold_last) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.cmd_seq   = (state_q == FILL);
      bus.cmd_delay = (state_q == HOLD);
      bus.busy      = (state_q == FILL) || (state_q == HOLD);
   end

   // Edge detector and LFSR run regardless of enable; done is a one-shot that always self-clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         lights_q    <= '0;
         done_q      <= 1'b0;
         trig_q      <= 1'b0;
         delay_cnt_q <= '0;
         lfsr_q      <= LFSR_W'(1);
      end else begin
         trig_q <= bus.trigger;
         lfsr_q <= {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[2]};
         done_q <= 1'b0;
         if (bus.en) begin
            case (state_q)
               IDLE: lights_q <= '0;
               FILL: begin
                  if (bus.tick) begin
                     lights_q <= {lights_q[N_LIGHTS-2:0], 1'b1};
                  end
                  if (fill_last) begin
                     delay_cnt_q <= lfsr_q;
                  end
               end
               HOLD: begin
                  if (hold_last) begin
                     lights_q <= '0;
                     done_q   <= 1'b1;
                  end else if (bus.tick) begin
                     delay_cnt_q <= delay_cnt_q - LFSR_W'(1);
                  end
               end
               default: lights_q <= '0;
            endcase
         end
      end
   end

   assign bus.lights = lights_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_f1_start_lights.sv
// Self-checking bench for f1_start_lights: directed scenarios plus randomized
// stimulus compared against a lamp-count / tick-count reference model.
module tb_f1_start_lights;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   f1_start_lights_if #(.N_LIGHTS(N)) bus ();
   f1_start_lights #(.N_LIGHTS(N), .LFSR_W(7)) u_dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: mode 0 idle / 1 fill / 2 hold, number of lit lamps, remaining hold ticks.
   int m_mode = 0;
   int m_lit  = 0;
   int m_rem  = 0;
   int m_lfsr = 1;
   bit m_done = 1'b0;
   bit m_trig_q = 1'b0;

   function automatic int lfsr_step(int x);
      return ((x * 2) % 128) + (((x / 64) ^ (x / 4)) % 2);
   endfunction

   function automatic logic [N-1:0] bar(int k);
      logic [63:0] v;
      v = (64'd1 << k) - 64'd1;
      return v[N-1:0];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_lit = 0; m_rem = 0; m_done = 1'b0; m_trig_q = 1'b0; m_lfsr = 1;
      end else begin
         bit start;
         start  = bus.trigger && !m_trig_q;
         m_done = 1'b0;
         if (bus.en) begin
            if (m_mode == 0) begin
               if (start) begin m_mode = 1; m_lit = 0; end
            end else if (m_mode == 1) begin
               if (bus.tick) begin
                  m_lit++;
                  if (m_lit == N) begin m_mode = 2; m_rem = m_lfsr; end
               end
            end else if (bus.tick) begin
               if (m_rem == 1) begin m_mode = 0; m_lit = 0; m_done = 1'b1; end
               else m_rem--;
            end
         end
         m_trig_q = bus.trigger;
         m_lfsr   = lfsr_step(m_lfsr);
      end
   end

   task automatic cyc(int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick_step();
      bus.tick = 1'b1;
      cyc(1);
      bus.tick = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.en = 1'b1; bus.tick = 1'b0; bus.trigger = 1'b0;
      cyc(2);
      rst = 1'b0;
      checks++; if (bus.lights !== '0) begin errors++; $display("FAIL reset_lights got %h exp %h", bus.lights, 8'h00); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.cmd_seq !== 1'b0) begin errors++; $display("FAIL reset_cmd_seq got %b exp 0", bus.cmd_seq); end
      checks++; if (bus.cmd_delay !== 1'b0) begin errors++; $display("FAIL reset_cmd_delay got %b exp 0", bus.cmd_delay); end
      cyc(1);
   endtask

   task automatic test_fill_hold();
      int d;
      bus.trigger = 1'b0; cyc(1);
      bus.trigger = 1'b1; cyc(1);
      checks++; if (bus.cmd_seq !== 1'b1) begin errors++; $display("FAIL fill_start_cmd_seq got %b exp 1", bus.cmd_seq); end
      checks++; if (bus.lights !== '0) begin errors++; $display("FAIL fill_start_lights got %h exp 00", bus.lights); end
      cyc(3);
      for (int k = 1; k <= N; k++) begin
         tick_step();
         checks++; if (bus.lights !== bar(k)) begin errors++; $display("FAIL fill_lights tick %0d got %h exp %h", k, bus.lights, bar(k)); end
         checks++; if (bus.cmd_seq !== (k < N)) begin errors++; $display("FAIL fill_cmd_seq tick %0d got %b exp %b", k, bus.cmd_seq, (k < N)); end
         checks++; if (bus.cmd_delay !== (k == N)) begin errors++; $display("FAIL fill_cmd_delay tick %0d got %b exp %b", k, bus.cmd_delay, (k == N)); end
         cyc(3);
      end
      d = m_rem;
      checks++; if (d < 1 || d > 127) begin errors++; $display("FAIL hold_delay_range got %0d exp 1..127", d); end
      bus.trigger = 1'b0;
      for (int j = 1; j <= d; j++) begin
         tick_step();
         if (j < d) begin
            checks++; if (bus.lights !== '1 || bus.done !== 1'b0) begin errors++; $display("FAIL hold_lights tick %0d got %h/%b exp ff/0", j, bus.lights, bus.done); end
         end else begin
            checks++; if (bus.lights !== '0) begin errors++; $display("FAIL hold_end_lights got %h exp 00", bus.lights); end
            checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL hold_end_done got %b exp 1", bus.done); end
            checks++; if (bus.busy !== 1'b0 || bus.cmd_delay !== 1'b0) begin errors++; $display("FAIL hold_end_status got busy %b delay %b exp 0 0", bus.busy, bus.cmd_delay); end
         end
         cyc(3);
      end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got %b exp 0", bus.done); end
   endtask

   task automatic test_held_trigger();
      int dones = 0;
      bit finished = 1'b0;
      bus.trigger = 1'b0; cyc(1);
      bus.trigger = 1'b1;
      for (int c = 0; c < 1200 && !finished; c++) begin
         bus.tick = (c % 4 == 3);
         if ((c % 9 == 4) && (m_mode == 1 || (m_mode == 2 && m_rem > 2))) bus.trigger = 1'b0;
         else bus.trigger = 1'b1;
         cyc(1);
         checks++; if (bus.lights !== bar(m_lit) || bus.busy !== (m_mode != 0)) begin errors++; $display("FAIL held_run c %0d got %h/%b exp %h/%b", c, bus.lights, bus.busy, bar(m_lit), (m_mode != 0)); end
         if (bus.done === 1'b1) dones++;
         if (m_done || bus.done === 1'b1) finished = 1'b1;
      end
      checks++; if (!finished) begin errors++; $display("FAIL held_timeout got no done exp done within 1200 clk"); end
      bus.trigger = 1'b1;
      for (int c = 0; c < 40; c++) begin
         bus.tick = (c % 4 == 0);
         cyc(1);
         if (bus.done === 1'b1) dones++;
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_no_restart c %0d got busy %b exp 0", c, bus.busy); end
      end
      bus.tick = 1'b0;
      checks++; if (dones !== 1) begin errors++; $display("FAIL held_one_sequence got %0d dones exp 1", dones); end
      bus.trigger = 1'b0; cyc(1);
      bus.trigger = 1'b1; cyc(1);
      checks++; if (bus.busy !== 1'b1 || bus.cmd_seq !== 1'b1) begin errors++; $display("FAIL held_new_edge got busy %b seq %b exp 1 1", bus.busy, bus.cmd_seq); end
   endtask

   task automatic test_enable();
      rst = 1'b1; bus.trigger = 1'b0; bus.tick = 1'b0; bus.en = 1'b1; cyc(1);
      rst = 1'b0;
      bus.trigger = 1'b1; cyc(4);
      for (int k = 0; k < 3; k++) begin tick_step(); cyc(3); end
      checks++; if (bus.lights !== 8'h07) begin errors++; $display("FAIL en_before got %h exp 07", bus.lights); end
      bus.en = 1'b0;
      for (int c = 0; c < 10; c++) begin
         bus.tick = (c % 4 == 0);
         cyc(1);
         checks++; if (bus.lights !== 8'h07) begin errors++; $display("FAIL en_frozen c %0d got %h exp 07", c, bus.lights); end
      end
      bus.tick = 1'b0; bus.en = 1'b1; cyc(2);
      checks++; if (bus.lights !== 8'h07) begin errors++; $display("FAIL en_resume_hold got %h exp 07", bus.lights); end
      tick_step();
      checks++; if (bus.lights !== 8'h0f) begin errors++; $display("FAIL en_resume_tick got %h exp 0f", bus.lights); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) begin cyc(3); tick_step(); end
      checks++; if (bus.lights !== 8'hff || bus.cmd_delay !== 1'b1) begin errors++; $display("FAIL mid_in_hold got %h/%b exp ff/1", bus.lights, bus.cmd_delay); end
      cyc(2);
      rst = 1'b1; cyc(1); rst = 1'b0;
      checks++; if (bus.lights !== '0) begin errors++; $display("FAIL mid_rst_lights got %h exp 00", bus.lights); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_status got busy %b done %b exp 0 0", bus.busy, bus.done); end
      bus.trigger = 1'b0;
      cyc(1);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_after got busy %b done %b exp 0 0", bus.busy, bus.done); end
   endtask

   task automatic test_same_cycle();
      bus.trigger = 1'b0; bus.tick = 1'b0; cyc(2);
      bus.trigger = 1'b1; bus.tick = 1'b1; cyc(1);
      bus.tick = 1'b0;
      checks++; if (bus.lights !== '0 || bus.cmd_seq !== 1'b1) begin errors++; $display("FAIL same_cycle got %h/%b exp 00/1", bus.lights, bus.cmd_seq); end
      cyc(2);
      tick_step();
      checks++; if (bus.lights !== 8'h01) begin errors++; $display("FAIL same_cycle_first got %h exp 01", bus.lights); end
   endtask

   task automatic test_random();
      rst = 1'b1; bus.en = 1'b1; bus.tick = 1'b0; bus.trigger = 1'b0; cyc(1);
      rst = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         rst         = ($urandom_range(0, 399) == 0);
         bus.en      = ($urandom_range(0, 7) != 0);
         bus.tick    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 14) == 0) bus.trigger = ~bus.trigger;
         cyc(1);
         checks++; if (bus.lights !== bar(m_lit)) begin errors++; $display("FAIL rnd_lights c %0d got %h exp %h", c, bus.lights, bar(m_lit)); end
         checks++; if (bus.done !== m_done) begin errors++; $display("FAIL rnd_done c %0d got %b exp %b", c, bus.done, m_done); end
         checks++; if (bus.cmd_seq !== (m_mode == 1)) begin errors++; $display("FAIL rnd_cmd_seq c %0d got %b exp %b", c, bus.cmd_seq, (m_mode == 1)); end
         checks++; if (bus.cmd_delay !== (m_mode == 2)) begin errors++; $display("FAIL rnd_cmd_delay c %0d got %b exp %b", c, bus.cmd_delay, (m_mode == 2)); end
         checks++; if (bus.busy !== (m_mode != 0)) begin errors++; $display("FAIL rnd_busy c %0d got %b exp %b", c, bus.busy, (m_mode != 0)); end
      end
      rst = 1'b0;
   endtask

   initial begin
      bus.en = 1'b1; bus.tick = 1'b0; bus.trigger = 1'b0;
      test_reset();
      test_fill_hold();
      test_held_trigger();
      test_enable();
      test_reset_mid();
      test_same_cycle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
